// File: rtl/handshake_arb_syn.sv
// handshake_arb_syn: per-channel one-entry holding registers arbitrated round-robin onto one
// req/ack link, 4-phase (PHASE4=1) or 2-phase toggle (PHASE4=0).
module handshake_arb_syn #(
    parameter int WIDTH  = 8,
    parameter int NCH    = 4,
    parameter int CHW    = 2,
    parameter int PHASE4 = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH-1:0]       ch_valid,
    input  logic [NCH*WIDTH-1:0] ch_data,
    output logic [NCH-1:0]       ch_idle,
    output logic                 req,
    input  logic                 ack,
    output logic [WIDTH-1:0]     dout,
    output logic [CHW-1:0]       dch,
    output logic                 busy
);
    typedef enum logic [1:0] {IDLE, REQ, REL} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] hold_q [NCH];
    logic [NCH-1:0]   idle_q;
    logic             req_q, busy_q;
    logic [WIDTH-1:0] dout_q;
    logic [CHW-1:0]   dch_q, ptr_q, gnt_d, ptr_d;
    logic             gnt_v, quiet, done;

    // Scan downward so the last hit is the first pending channel at or after ptr.
    always_comb begin
        gnt_d = '0;
        for (int k = NCH - 1; k >= 0; k--)
            if (!idle_q[(int'(ptr_q) + k) % NCH])
                gnt_d = CHW'((int'(ptr_q) + k) % NCH);
    end

    assign gnt_v = ~&idle_q;
    assign ptr_d = (gnt_d == CHW'(NCH - 1)) ? '0 : gnt_d + CHW'(1);
    assign quiet = (PHASE4 != 0) ? !ack : (ack == req_q);
    assign done  = (PHASE4 != 0) ? ack : (ack == req_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idle_q  <= '1;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            dout_q  <= '0;
            dch_q   <= '0;
            for (int i = 0; i < NCH; i++)
                hold_q[i] <= '0;
        end else begin
            for (int i = 0; i < NCH; i++)
                if (idle_q[i] && ch_valid[i]) begin
                    hold_q[i] <= ch_data[i*WIDTH +: WIDTH];
                    idle_q[i] <= 1'b0;
                end
            case (state_q)
                IDLE: if (gnt_v && quiet) begin
                    dout_q  <= hold_q[gnt_d];
                    dch_q   <= gnt_d;
                    ptr_q   <= ptr_d;
                    req_q   <= (PHASE4 != 0) ? 1'b1 : ~req_q;
                    state_q <= REQ;
                    busy_q  <= 1'b1;
                end
                REQ: if (done) begin
                    idle_q[dch_q] <= 1'b1;
                    req_q         <= (PHASE4 != 0) ? 1'b0 : req_q;
                    state_q       <= (PHASE4 != 0) ? REL : IDLE;
                    busy_q        <= PHASE4 != 0;
                end
                REL: if (!ack) begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ch_idle = idle_q;
    assign req     = req_q;
    assign dout    = dout_q;
    assign dch     = dch_q;
    assign busy    = busy_q;
endmodule

// File: tb/tb_handshake_arb_syn.sv
// tb_handshake_arb_syn: directed checks of a 4-phase and a 2-phase instance.
module tb_handshake_arb_syn;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  v4 = '0, v2 = '0;
    logic [31:0] d4 = '0, d2 = '0;
    logic        ack4 = 1'b0, ack2 = 1'b0;
    logic [3:0]  idle4, idle2;
    logic        req4, req2, busy4, busy2;
    logic [7:0]  dout4, dout2;
    logic [1:0]  dch4, dch2;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    handshake_arb_syn #(.WIDTH(8), .NCH(4), .CHW(2), .PHASE4(1)) u4 (
        .clk(clk), .rst(rst), .ch_valid(v4), .ch_data(d4), .ch_idle(idle4),
        .req(req4), .ack(ack4), .dout(dout4), .dch(dch4), .busy(busy4)
    );

    handshake_arb_syn #(.WIDTH(8), .NCH(4), .CHW(2), .PHASE4(0)) u2 (
        .clk(clk), .rst(rst), .ch_valid(v2), .ch_data(d2), .ch_idle(idle2),
        .req(req2), .ack(ack2), .dout(dout2), .dch(dch2), .busy(busy2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // 4-phase: req must already be up; raise ack, drop it, end back in IDLE.
    task automatic serve4(input string tag, input logic [7:0] ed, input logic [1:0] ec);
        chk({tag, " req"}, 32'(req4), 32'd1);
        chk({tag, " dout"}, 32'(dout4), 32'(ed));
        chk({tag, " dch"}, 32'(dch4), 32'(ec));
        ack4 = 1'b1;
        tick();
        chk({tag, " req drop"}, 32'(req4), 32'd0);
        chk({tag, " freed"}, 32'(idle4[ec]), 32'd1);
        ack4 = 1'b0;
        tick();
        chk({tag, " idle busy"}, 32'(busy4), 32'd0);
    endtask

    initial begin
        tick();
        tick();
        chk("rst idle", 32'(idle4), 32'hF);
        chk("rst req", 32'(req4), 32'd0);
        chk("rst dout", 32'(dout4), 32'd0);
        chk("rst dch", 32'(dch4), 32'd0);
        chk("rst busy", 32'(busy4), 32'd0);
        chk("rst idle2", 32'(idle2), 32'hF);
        rst = 1'b0;
        tick();

        // single word on ch0, ack echoes after 2 cycles
        v4 = 4'b0001; d4 = 32'h0000_00A5;
        tick();
        v4 = '0;
        chk("t1 captured", 32'(idle4), 32'hE);
        chk("t1 no req yet", 32'(req4), 32'd0);
        tick();
        chk("t1 busy", 32'(busy4), 32'd1);
        tick();
        tick();
        serve4("t1", 8'hA5, 2'd0);
        chk("t1 all idle", 32'(idle4), 32'hF);

        // reset pulse to bring ptr back to 0
        rst = 1'b1; #2; rst = 1'b0;
        tick();

        // all four loaded on one edge: 0,1,2,3
        v4 = 4'b1111; d4 = 32'h4433_2211;
        tick();
        v4 = '0;
        chk("t2 all held", 32'(idle4), 32'h0);
        tick();
        serve4("t2 g0", 8'h11, 2'd0);
        tick();
        serve4("t2 g1", 8'h22, 2'd1);
        tick();
        serve4("t2 g2", 8'h33, 2'd2);
        tick();
        serve4("t2 g3", 8'h44, 2'd3);
        chk("t2 done", 32'(idle4), 32'hF);

        // ptr back at 0: ch0 beats ch3
        v4 = 4'b1001; d4 = 32'h3000_000C;
        tick();
        v4 = '0;
        tick();
        serve4("ptr0 g0", 8'h0C, 2'd0);
        tick();
        serve4("ptr0 g3", 8'h30, 2'd3);

        // ch2 alone leaves ptr=3; then ch0+ch2 -> ch0 first via wrap
        v4 = 4'b0100; d4 = 32'h0077_0000;
        tick();
        v4 = '0;
        tick();
        serve4("t3 pre", 8'h77, 2'd2);
        v4 = 4'b0101; d4 = 32'h0020_0010;
        tick();
        v4 = '0;
        tick();
        serve4("t3 wrap g0", 8'h10, 2'd0);
        tick();
        serve4("t3 wrap g2", 8'h20, 2'd2);

        // overwrite while held is dropped
        v4 = 4'b0010; d4 = 32'h0000_5A00;
        tick();
        d4 = 32'h0000_FF00;
        tick();
        v4 = '0;
        chk("t4 held", 32'(idle4), 32'hD);
        serve4("t4", 8'h5A, 2'd1);
        tick();
        chk("t4 no second req", 32'(req4), 32'd0);
        chk("t4 no second busy", 32'(busy4), 32'd0);

        // ack high in IDLE blocks grants in 4-phase mode
        ack4 = 1'b1;
        v4 = 4'b0001; d4 = 32'h0000_0099;
        tick();
        v4 = '0;
        tick();
        tick();
        chk("blk req", 32'(req4), 32'd0);
        chk("blk busy", 32'(busy4), 32'd0);
        ack4 = 1'b0;
        tick();
        serve4("blk", 8'h99, 2'd0);

        // 2-phase toggle handshake, three words
        v2 = 4'b0111; d2 = 32'h00C3_B2A1;
        tick();
        v2 = '0;
        chk("t5 req0", 32'(req2), 32'd0);
        tick();
        chk("t5 w0 req", 32'(req2), 32'd1);
        chk("t5 w0 dout", 32'(dout2), 32'hA1);
        chk("t5 w0 dch", 32'(dch2), 32'd0);
        ack2 = 1'b1;
        tick();
        chk("t5 w0 done", 32'(busy2), 32'd0);
        chk("t5 w0 freed", 32'(idle2), 32'h9);
        chk("t5 w0 req hold", 32'(req2), 32'd1);
        tick();
        chk("t5 w1 req", 32'(req2), 32'd0);
        chk("t5 w1 dout", 32'(dout2), 32'hB2);
        chk("t5 w1 dch", 32'(dch2), 32'd1);
        ack2 = 1'b0;
        tick();
        chk("t5 w1 done", 32'(busy2), 32'd0);
        tick();
        chk("t5 w2 req", 32'(req2), 32'd1);
        chk("t5 w2 dout", 32'(dout2), 32'hC3);
        chk("t5 w2 dch", 32'(dch2), 32'd2);
        ack2 = 1'b1;
        tick();
        chk("t5 w2 done", 32'(busy2), 32'd0);
        chk("t5 all idle", 32'(idle2), 32'hF);

        // async reset mid-REQ aborts the transfer
        v4 = 4'b0001; d4 = 32'h0000_0066;
        tick();
        v4 = '0;
        tick();
        chk("t6 in req", 32'(req4), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("t6 async req", 32'(req4), 32'd0);
        chk("t6 async idle", 32'(idle4), 32'hF);
        chk("t6 async dout", 32'(dout4), 32'd0);
        chk("t6 async busy", 32'(busy4), 32'd0);
        #1 rst = 1'b0;
        ack4 = 1'b1;
        tick();
        tick();
        chk("t6 ack ignored", 32'(req4), 32'd0);
        ack4 = 1'b0;
        tick();
        tick();
        chk("t6 no transfer", 32'(busy4), 32'd0);
        chk("t6 still idle", 32'(idle4), 32'hF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
